// File: rtl/pwm_kalp_atisi_uretici_pkg.sv
// -----------------------------------------------------------------------------
// pwm_kalp_atisi_uretici_pkg
// Shared definitions for the heartbeat-mode PWM generator and the PWM
// controller that drives it.
//   - durum_t : ramp FSM states (idle / rising / falling)
//   - mod_t   : per-channel mode encoding used by the controller
//   - default widths for period/threshold values and the increment step
// -----------------------------------------------------------------------------
package pwm_kalp_atisi_uretici_pkg;

    localparam int VARSAYILAN_GENISLIK      = 32;
    localparam int VARSAYILAN_ADIM_GENISLIK = 12;

    typedef enum logic [1:0] {
        BOSTA  = 2'b00,
        YUKARI = 2'b01,
        ASAGI  = 2'b10
    } durum_t;

    // Channel mode as seen by the controller; prefixed so it does not clash
    // with the FSM idle state name.
    typedef enum logic [1:0] {
        MOD_BOSTA      = 2'b00,
        MOD_STANDART   = 2'b01,
        MOD_KALP_ATISI = 2'b10
    } mod_t;

endpackage

// File: rtl/pwm_kalp_atisi_uretici_if.sv
// -----------------------------------------------------------------------------
// pwm_kalp_atisi_uretici_if
// Bundle between the PWM controller (master) and one heartbeat generator
// channel (slave).
//   aktif_i        : mode enable
//   periyot_i      : period length in clk cycles
//   esik_1_i       : lower duty threshold
//   esik_2_i       : upper duty threshold
//   artis_i        : threshold increment applied once per period
//   pwm_o          : registered PWM output
//   periyot_sonu_o : one-cycle pulse on the last cycle of each period
//   yon_o          : ramp direction, 1 = rising
// -----------------------------------------------------------------------------
interface pwm_kalp_atisi_uretici_if
    import pwm_kalp_atisi_uretici_pkg::*;
#(
    parameter int GENISLIK      = VARSAYILAN_GENISLIK,
    parameter int ADIM_GENISLIK = VARSAYILAN_ADIM_GENISLIK
);
    logic                     aktif_i;
    logic [GENISLIK-1:0]      periyot_i;
    logic [GENISLIK-1:0]      esik_1_i;
    logic [GENISLIK-1:0]      esik_2_i;
    logic [ADIM_GENISLIK-1:0] artis_i;
    logic                     pwm_o;
    logic                     periyot_sonu_o;
    logic                     yon_o;

    modport master (
        output aktif_i, periyot_i, esik_1_i, esik_2_i, artis_i,
        input  pwm_o, periyot_sonu_o, yon_o
    );

    modport slave (
        input  aktif_i, periyot_i, esik_1_i, esik_2_i, artis_i,
        output pwm_o, periyot_sonu_o, yon_o
    );

endinterface

// File: rtl/pwm_kalp_atisi_uretici_periyot_sayaci.sv
// -----------------------------------------------------------------------------
// pwm_periyot_sayaci
// Period counter with wrap, raw period-end flag and registered compare.
// Shared with the standard-mode generator.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   calis         : run enable; low holds counter and pwm at 0
//   periyot       : period length P (counter runs 0..P-1)
//   esik          : duty threshold; pwm is high while counter < esik
//   periyot_sonu  : counter == P-1 (combinational, not gated by calis)
//   pwm           : compare result, one cycle behind the counter
// -----------------------------------------------------------------------------
module pwm_periyot_sayaci #(
    parameter int GENISLIK = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                calis,
    input  logic [GENISLIK-1:0] periyot,
    input  logic [GENISLIK-1:0] esik,
    output logic                periyot_sonu,
    output logic                pwm
);
    localparam logic [GENISLIK-1:0] BIR = GENISLIK'(1);

    logic [GENISLIK-1:0] sayac;

    // With periyot = 0 the compare value is all-ones and never matches;
    // the owner keeps calis low in that case anyway.
    assign periyot_sonu = (sayac == periyot - BIR);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sayac <= '0;
            pwm   <= 1'b0;
        end else if (!calis) begin
            sayac <= '0;
            pwm   <= 1'b0;
        end else begin
            pwm   <= (sayac < esik);
            sayac <= periyot_sonu ? '0 : sayac + BIR;
        end
    end

endmodule

// File: rtl/pwm_kalp_atisi_uretici.sv
// -----------------------------------------------------------------------------
// pwm_kalp_atisi_uretici
// Heartbeat-mode PWM generator, one per channel. Fixed-period PWM whose duty
// threshold ramps triangularly between esik_1 and esik_2 by artis per period.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : slave side of pwm_kalp_atisi_uretici_if (config in, pwm out)
// -----------------------------------------------------------------------------
module pwm_kalp_atisi_uretici
    import pwm_kalp_atisi_uretici_pkg::*;
#(
    parameter int GENISLIK      = VARSAYILAN_GENISLIK,
    parameter int ADIM_GENISLIK = VARSAYILAN_ADIM_GENISLIK
) (
    input logic                     clk_i,
    input logic                     rst_ni,
    pwm_kalp_atisi_uretici_if.slave bus
);
    durum_t              durum;
    durum_t              durum_sonraki;
    logic [GENISLIK-1:0] esik;
    logic [GENISLIK-1:0] esik_sonraki;
    logic [GENISLIK-1:0] periyot_golge;
    logic [GENISLIK-1:0] artis;
    logic [GENISLIK:0]   yukari_toplam;
    logic [GENISLIK:0]   asagi_sinir;
    logic                calis;
    logic                sonu_ham;
    logic                periyot_sonu;

    // Dropping aktif_i stops the counter on the same edge the FSM goes idle.
    assign calis        = (durum != BOSTA) && bus.aktif_i;
    assign periyot_sonu = sonu_ham && (durum != BOSTA);

    assign bus.periyot_sonu_o = periyot_sonu;
    assign bus.yon_o          = (durum == YUKARI);

    pwm_periyot_sayaci #(
        .GENISLIK (GENISLIK)
    ) u_sayac (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .calis        (calis),
        .periyot      (periyot_golge),
        .esik         (esik),
        .periyot_sonu (sonu_ham),
        .pwm          (bus.pwm_o)
    );

    // esik_1/esik_2/artis are only consumed on the edge where a new period's
    // configuration is taken, so the active threshold register is their only
    // shadow; the period length needs a real shadow for the counter.
    assign artis         = GENISLIK'(bus.artis_i);
    assign yukari_toplam = {1'b0, esik} + {1'b0, artis};
    assign asagi_sinir   = {1'b0, bus.esik_1_i} + {1'b0, artis};

    // Next threshold/direction for the coming period; one bit of headroom
    // so neither the sum nor the lower bound can wrap.
    always_comb begin
        durum_sonraki = durum;
        esik_sonraki  = esik;
        if (bus.esik_1_i >= bus.esik_2_i) begin
            durum_sonraki = YUKARI;
            esik_sonraki  = bus.esik_1_i;
        end else if (durum == YUKARI) begin
            if (yukari_toplam >= {1'b0, bus.esik_2_i}) begin
                durum_sonraki = ASAGI;
                esik_sonraki  = bus.esik_2_i;
            end else begin
                esik_sonraki  = yukari_toplam[GENISLIK-1:0];
            end
        end else begin
            if ({1'b0, esik} <= asagi_sinir) begin
                durum_sonraki = YUKARI;
                esik_sonraki  = bus.esik_1_i;
            end else begin
                esik_sonraki  = esik - artis;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum         <= BOSTA;
            esik          <= '0;
            periyot_golge <= '0;
        end else if (!bus.aktif_i) begin
            durum <= BOSTA;
        end else begin
            case (durum)
                BOSTA: begin
                    if (bus.periyot_i != '0) begin
                        durum         <= YUKARI;
                        esik          <= bus.esik_1_i;
                        periyot_golge <= bus.periyot_i;
                    end
                end
                default: begin
                    if (periyot_sonu) begin
                        periyot_golge <= bus.periyot_i;
                        if (bus.periyot_i == '0) begin
                            durum <= BOSTA;
                        end else begin
                            durum <= durum_sonraki;
                            esik  <= esik_sonraki;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_kalp_atisi_uretici.sv
module tb_pwm_kalp_atisi_uretici;
    localparam int G = 32;
    localparam int A = 12;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    pwm_kalp_atisi_uretici_if #(.GENISLIK(G), .ADIM_GENISLIK(A)) bus ();

    pwm_kalp_atisi_uretici #(.GENISLIK(G), .ADIM_GENISLIK(A)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        int yuksek;
        bit yon;
        int uzunluk;
    } beklenen_t;

    beklenen_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic ayarla(input int p, input int e1, input int e2, input int a);
        bus.periyot_i = 32'(p);
        bus.esik_1_i  = 32'(e1);
        bus.esik_2_i  = 32'(e2);
        bus.artis_i   = 12'(a);
    endtask

    task automatic baslat(input int p, input int e1, input int e2, input int a);
        @(negedge clk);
        ayarla(p, e1, e2, a);
        bus.aktif_i = 1'b1;
    endtask

    task automatic durdur();
        @(negedge clk);
        bus.aktif_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Collects one period: pwm lags the counter by one cycle, so the period's
    // high count includes the first sample of the following period.
    // len0 = 0 for the first period after start, 1 for following periods.
    task automatic periyot_topla(input int len0, input int degis_idx,
                                 input int yp, input int ye1, input int ye2,
                                 output int yuksek, output bit yon,
                                 output int uzunluk, output bit asim);
        bit gordu;
        gordu = 1'b0;
        asim = 1'b1;
        yuksek = 0;
        yon = 1'b0;
        uzunluk = len0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            yuksek += int'(bus.pwm_o);
            if (gordu) begin
                asim = 1'b0;
                break;
            end
            uzunluk++;
            if (bus.periyot_sonu_o) begin
                gordu = 1'b1;
                yon = bus.yon_o;
            end
            if (i == degis_idx) begin
                bus.periyot_i = 32'(yp);
                bus.esik_1_i  = 32'(ye1);
                bus.esik_2_i  = 32'(ye2);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        bus.aktif_i = 1'b1;
        ayarla(10, 3, 3, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.pwm_o !== 1'b0) begin
            errors++; $display("FAIL reset_pwm got %b want 0", bus.pwm_o);
        end
        checks++;
        if (bus.yon_o !== 1'b0) begin
            errors++; $display("FAIL reset_yon got %b want 0", bus.yon_o);
        end
        checks++;
        if (bus.periyot_sonu_o !== 1'b0) begin
            errors++; $display("FAIL reset_sonu got %b want 0", bus.periyot_sonu_o);
        end
        bus.aktif_i = 1'b0;
        rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.pwm_o, bus.yon_o, bus.periyot_sonu_o} !== 3'b000) begin
                errors++;
                $display("FAIL idle_outputs cycle %0d got %b want 000", i,
                         {bus.pwm_o, bus.yon_o, bus.periyot_sonu_o});
            end
        end
    endtask

    task automatic test_fixed();
        int yk, uz; bit yn, asim; beklenen_t b;
        for (int i = 0; i < 4; i++) sb.push_back(beklenen_t'{3, 1'b1, 10});
        baslat(10, 3, 3, 1);
        for (int i = 0; i < 4; i++) begin
            periyot_topla(i == 0 ? 0 : 1, -1, 0, 0, 0, yk, yn, uz, asim);
            b = sb.pop_front();
            checks++;
            if (asim) begin errors++; $display("FAIL fixed_timeout period %0d got timeout want period end", i); end
            checks++;
            if (yk !== b.yuksek) begin errors++; $display("FAIL fixed_high period %0d got %0d want %0d", i, yk, b.yuksek); end
            checks++;
            if (uz !== b.uzunluk) begin errors++; $display("FAIL fixed_len period %0d got %0d want %0d", i, uz, b.uzunluk); end
            checks++;
            if (yn !== b.yon) begin errors++; $display("FAIL fixed_yon period %0d got %b want %b", i, yn, b.yon); end
        end
        durdur();
    endtask

    task automatic test_ramp();
        int h[7] = '{2, 4, 6, 4, 2, 4, 6};
        bit y[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int yk, uz; bit yn, asim; beklenen_t b;
        for (int i = 0; i < 7; i++) sb.push_back(beklenen_t'{h[i], y[i], 8});
        baslat(8, 2, 6, 2);
        for (int i = 0; i < 7; i++) begin
            periyot_topla(i == 0 ? 0 : 1, -1, 0, 0, 0, yk, yn, uz, asim);
            b = sb.pop_front();
            checks++;
            if (asim) begin errors++; $display("FAIL ramp_timeout period %0d got timeout want period end", i); end
            checks++;
            if (yk !== b.yuksek) begin errors++; $display("FAIL ramp_high period %0d got %0d want %0d", i, yk, b.yuksek); end
            checks++;
            if (uz !== b.uzunluk) begin errors++; $display("FAIL ramp_len period %0d got %0d want %0d", i, uz, b.uzunluk); end
            checks++;
            if (yn !== b.yon) begin errors++; $display("FAIL ramp_yon period %0d got %b want %b", i, yn, b.yon); end
        end
        durdur();
    endtask

    task automatic test_saturation();
        int h[6] = '{1, 5, 6, 2, 1, 5};
        bit y[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int yk, uz; bit yn, asim; beklenen_t b;
        for (int i = 0; i < 6; i++) sb.push_back(beklenen_t'{h[i], y[i], 8});
        baslat(8, 1, 6, 4);
        for (int i = 0; i < 6; i++) begin
            periyot_topla(i == 0 ? 0 : 1, -1, 0, 0, 0, yk, yn, uz, asim);
            b = sb.pop_front();
            checks++;
            if (asim) begin errors++; $display("FAIL sat_timeout period %0d got timeout want period end", i); end
            checks++;
            if (yk !== b.yuksek) begin errors++; $display("FAIL sat_high period %0d got %0d want %0d", i, yk, b.yuksek); end
            checks++;
            if (yn !== b.yon) begin errors++; $display("FAIL sat_yon period %0d got %b want %b", i, yn, b.yon); end
        end
        durdur();
    endtask

    task automatic test_shadow();
        int di[3] = '{4, -1, 3};
        int np[3] = '{10, 0, 0};
        int yk, uz; bit yn, asim; beklenen_t b;
        sb.push_back(beklenen_t'{3, 1'b1, 10});
        sb.push_back(beklenen_t'{7, 1'b1, 10});
        sb.push_back(beklenen_t'{7, 1'b1, 10});
        baslat(10, 3, 3, 1);
        for (int i = 0; i < 3; i++) begin
            periyot_topla(i == 0 ? 0 : 1, di[i], np[i], 7, 7, yk, yn, uz, asim);
            b = sb.pop_front();
            checks++;
            if (asim) begin errors++; $display("FAIL shadow_timeout period %0d got timeout want period end", i); end
            checks++;
            if (yk !== b.yuksek) begin errors++; $display("FAIL shadow_high period %0d got %0d want %0d", i, yk, b.yuksek); end
            checks++;
            if (uz !== b.uzunluk) begin errors++; $display("FAIL shadow_len period %0d got %0d want %0d", i, uz, b.uzunluk); end
        end
        // Zero period was latched at the last period end: generator is idle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.pwm_o, bus.yon_o, bus.periyot_sonu_o} !== 3'b000) begin
                errors++;
                $display("FAIL zero_period cycle %0d got %b want 000", i,
                         {bus.pwm_o, bus.yon_o, bus.periyot_sonu_o});
            end
        end
        durdur();
    endtask

    task automatic test_disable();
        int yk, uz; bit yn, asim; bit bulundu; beklenen_t b;
        baslat(10, 6, 6, 0);
        bulundu = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pwm_o === 1'b1) begin
                bulundu = 1'b1;
                break;
            end
        end
        checks++;
        if (!bulundu) begin errors++; $display("FAIL disable_wait_high got timeout want pwm 1"); end
        bus.aktif_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.pwm_o, bus.yon_o} !== 2'b00) begin
            errors++; $display("FAIL disable_outputs got %b want 00", {bus.pwm_o, bus.yon_o});
        end
        // Restart with zero increment: counter from 0, threshold from esik_1.
        for (int i = 0; i < 2; i++) sb.push_back(beklenen_t'{2, 1'b1, 10});
        baslat(10, 2, 5, 0);
        for (int i = 0; i < 2; i++) begin
            periyot_topla(i == 0 ? 0 : 1, -1, 0, 0, 0, yk, yn, uz, asim);
            b = sb.pop_front();
            checks++;
            if (yk !== b.yuksek) begin errors++; $display("FAIL restart_high period %0d got %0d want %0d", i, yk, b.yuksek); end
            checks++;
            if (uz !== b.uzunluk) begin errors++; $display("FAIL restart_len period %0d got %0d want %0d", i, uz, b.uzunluk); end
            checks++;
            if (yn !== b.yon) begin errors++; $display("FAIL restart_yon period %0d got %b want %b", i, yn, b.yon); end
        end
        durdur();
    endtask

    task automatic test_sinirlar();
        int pp[3] = '{4, 5, 8};
        int e1[3] = '{9, 0, 5};
        int e2[3] = '{9, 0, 2};
        int hh[3] = '{4, 0, 5};
        int yk, uz; bit yn, asim; beklenen_t b;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2; i++) sb.push_back(beklenen_t'{hh[k], 1'b1, pp[k]});
            baslat(pp[k], e1[k], e2[k], 1);
            for (int i = 0; i < 2; i++) begin
                periyot_topla(i == 0 ? 0 : 1, -1, 0, 0, 0, yk, yn, uz, asim);
                b = sb.pop_front();
                checks++;
                if (yk !== b.yuksek) begin errors++; $display("FAIL bound%0d_high period %0d got %0d want %0d", k, i, yk, b.yuksek); end
                checks++;
                if (uz !== b.uzunluk) begin errors++; $display("FAIL bound%0d_len period %0d got %0d want %0d", k, i, uz, b.uzunluk); end
                checks++;
                if (yn !== b.yon) begin errors++; $display("FAIL bound%0d_yon period %0d got %b want %b", k, i, yn, b.yon); end
            end
            durdur();
        end
    endtask

    task automatic test_async_reset();
        bit bulundu;
        baslat(10, 6, 6, 0);
        bulundu = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.pwm_o === 1'b1) begin
                bulundu = 1'b1;
                break;
            end
        end
        checks++;
        if (!bulundu) begin errors++; $display("FAIL areset_wait_high got timeout want pwm 1"); end
        #1 rst_ni = 1'b0;
        #1;
        checks++;
        if ({bus.pwm_o, bus.yon_o, bus.periyot_sonu_o} !== 3'b000) begin
            errors++;
            $display("FAIL areset_immediate got %b want 000", {bus.pwm_o, bus.yon_o, bus.periyot_sonu_o});
        end
        @(negedge clk);
        bus.aktif_i = 1'b0;
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.pwm_o, bus.yon_o} !== 2'b00) begin
            errors++; $display("FAIL areset_after got %b want 00", {bus.pwm_o, bus.yon_o});
        end
    endtask

    initial begin
        bus.aktif_i   = 1'b0;
        bus.periyot_i = '0;
        bus.esik_1_i  = '0;
        bus.esik_2_i  = '0;
        bus.artis_i   = '0;
        test_reset();
        test_fixed();
        test_ramp();
        test_saturation();
        test_shadow();
        test_disable();
        test_sinirlar();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
